// File: rtl/avi_info_frame_parser.sv
// AVI InfoFrame receiver: gathers HB0-HB2/PB0-PB27, validates type/version/length/checksum, latches decoded fields.
// Optional feature macro: AVI_BAR_INFO_EN (adds bar_top/bar_bottom/bar_left/bar_right from PB6-PB13).
module avi_info_frame_parser #(
  parameter logic [7:0] EXPECT_VERSION = 8'd2,
  parameter bit         STRICT_VERSION = 1'b1,
  parameter logic [4:0] MAX_LENGTH     = 5'd27
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        pkt_start,
  input  logic        pkt_valid,
  input  logic [7:0]  pkt_byte,
  output logic        avi_valid,
  output logic [39:0] avi_fields,
  output logic [1:0]  video_format,
  output logic [1:0]  colorimetry,
  output logic [6:0]  video_id_code,
  output logic [3:0]  pixel_repetition,
  output logic        checksum_err,
  output logic        format_err,
`ifdef AVI_BAR_INFO_EN
  output logic [15:0] bar_top,
  output logic [15:0] bar_bottom,
  output logic [15:0] bar_left,
  output logic [15:0] bar_right,
`endif
  output logic        abort_err
);

  localparam logic [7:0] AVI_TYPE = 8'h82;
  localparam logic [4:0] LAST_CNT = 5'd30;

  typedef enum logic [2:0] {IDLE, HEADER, BODY, SKIP, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  hb1_q, hb1_d;
  logic [4:0]  len_q, len_d;
  logic        is_avi_q, is_avi_d;
  logic        reject_q, reject_d;
  logic [39:0] shadow_q, shadow_d;
  logic [39:0] fields_q, fields_d;
  logic        avi_valid_q, avi_valid_d;
  logic        ck_err_q, ck_err_d;
  logic        fmt_err_q, fmt_err_d;
  logic        abort_q, abort_d;
  logic        start_fire, in_len, hdr_bad, restart;
  logic [7:0]  sum, body_acc;
`ifdef AVI_BAR_INFO_EN
  logic [63:0] bar_shadow_q, bar_shadow_d;
  logic [63:0] bar_q, bar_d;
`endif

  assign start_fire = pkt_valid && pkt_start;
  assign sum        = acc_q + pkt_byte;
  // PB index k = cnt-3; only PB0..PB(len) contribute to the checksum
  assign in_len     = ({1'b0, cnt_q} <= ({1'b0, len_q} + 6'd3));
  assign body_acc   = in_len ? sum : acc_q;
  assign hdr_bad    = (STRICT_VERSION && (hb1_q != EXPECT_VERSION)) ||
                      (pkt_byte[7:5] != 3'd0) || (pkt_byte[4:0] > MAX_LENGTH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    hb1_d       = hb1_q;
    len_d       = len_q;
    is_avi_d    = is_avi_q;
    reject_d    = reject_q;
    shadow_d    = shadow_q;
    fields_d    = fields_q;
    avi_valid_d = 1'b0;
    ck_err_d    = 1'b0;
    fmt_err_d   = 1'b0;
    abort_d     = 1'b0;
    restart     = 1'b0;
`ifdef AVI_BAR_INFO_EN
    bar_shadow_d = bar_shadow_q;
    bar_d        = bar_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        restart = start_fire;
      end
      HEADER, BODY, SKIP: begin
        if (start_fire) begin
          restart = 1'b1;
          abort_d = is_avi_q;
        end else if (pkt_valid) begin
          if (state_q == HEADER) begin
            acc_d = sum;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd1) begin
              hb1_d = pkt_byte;
            end else begin
              len_d = pkt_byte[4:0];
              if (hdr_bad) begin
                state_d  = SKIP;
                reject_d = 1'b1;
              end else begin
                state_d = BODY;
              end
            end
          end else if (state_q == BODY) begin
            acc_d = body_acc;
            for (int i = 0; i < 5; i++) begin
              if (cnt_q == 5'(i + 4)) shadow_d[8*i +: 8] = pkt_byte;
            end
`ifdef AVI_BAR_INFO_EN
            for (int i = 0; i < 8; i++) begin
              if (cnt_q == 5'(i + 9)) bar_shadow_d[8*i +: 8] = pkt_byte;
            end
`endif
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
              cnt_d   = 5'd0;
              if (body_acc == 8'd0) begin
                avi_valid_d = 1'b1;
                fields_d    = shadow_q;
`ifdef AVI_BAR_INFO_EN
                if (shadow_q[3:2] != 2'd0) bar_d = bar_shadow_q;
`endif
              end else begin
                ck_err_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            if (cnt_q == LAST_CNT) begin
              state_d   = IDLE;
              cnt_d     = 5'd0;
              fmt_err_d = reject_q;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A qualified start always begins a fresh packet, whatever was in flight
    if (restart) begin
      acc_d    = pkt_byte;
      cnt_d    = 5'd1;
      is_avi_d = (pkt_byte == AVI_TYPE);
      reject_d = 1'b0;
      state_d  = (pkt_byte == AVI_TYPE) ? HEADER : SKIP;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      acc_q       <= 8'd0;
      hb1_q       <= 8'd0;
      len_q       <= 5'd0;
      is_avi_q    <= 1'b0;
      reject_q    <= 1'b0;
      shadow_q    <= 40'd0;
      fields_q    <= 40'd0;
      avi_valid_q <= 1'b0;
      ck_err_q    <= 1'b0;
      fmt_err_q   <= 1'b0;
      abort_q     <= 1'b0;
`ifdef AVI_BAR_INFO_EN
      bar_shadow_q <= 64'd0;
      bar_q        <= 64'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      hb1_q       <= hb1_d;
      len_q       <= len_d;
      is_avi_q    <= is_avi_d;
      reject_q    <= reject_d;
      shadow_q    <= shadow_d;
      fields_q    <= fields_d;
      avi_valid_q <= avi_valid_d;
      ck_err_q    <= ck_err_d;
      fmt_err_q   <= fmt_err_d;
      abort_q     <= abort_d;
`ifdef AVI_BAR_INFO_EN
      bar_shadow_q <= bar_shadow_d;
      bar_q        <= bar_d;
`endif
    end
  end

  assign avi_valid        = avi_valid_q;
  assign checksum_err     = ck_err_q;
  assign format_err       = fmt_err_q;
  assign abort_err        = abort_q;
  // avi_fields packs {PB5,PB4,PB3,PB2,PB1} with PB1 in the low byte
  assign avi_fields       = fields_q;
  assign video_format     = fields_q[6:5];
  assign colorimetry      = fields_q[15:14];
  assign video_id_code    = fields_q[30:24];
  assign pixel_repetition = fields_q[35:32];
`ifdef AVI_BAR_INFO_EN
  assign bar_top    = bar_q[15:0];
  assign bar_bottom = bar_q[31:16];
  assign bar_left   = bar_q[47:32];
  assign bar_right  = bar_q[63:48];
`endif

endmodule

// File: tb/tb_avi_info_frame_parser.sv
// Self-checking bench for avi_info_frame_parser: table of frames plus abort/reset sequences, scoreboard on result pulses.
module tb_avi_info_frame_parser;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        pkt_start;
  logic        pkt_valid;
  logic [7:0]  pkt_byte;
  logic        avi_valid;
  logic [39:0] avi_fields;
  logic [1:0]  video_format;
  logic [1:0]  colorimetry;
  logic [6:0]  video_id_code;
  logic [3:0]  pixel_repetition;
  logic        checksum_err;
  logic        format_err;
  logic        abort_err;

  avi_info_frame_parser dut (
    .clk_pixel        (clk_pixel),
    .reset_n          (reset_n),
    .pkt_start        (pkt_start),
    .pkt_valid        (pkt_valid),
    .pkt_byte         (pkt_byte),
    .avi_valid        (avi_valid),
    .avi_fields       (avi_fields),
    .video_format     (video_format),
    .colorimetry      (colorimetry),
    .video_id_code    (video_id_code),
    .pixel_repetition (pixel_repetition),
    .checksum_err     (checksum_err),
    .format_err       (format_err),
    .abort_err        (abort_err)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [7:0] hb0, hb1, hb2, pb1, pb2, pb4, pb5, junk, ck_delta;
    bit         stall;
  } vec_t;

  // pulses = {abort_err, format_err, checksum_err, avi_valid}
  typedef struct {
    int unsigned due;
    logic [3:0]  pulses;
    logic [39:0] fields;
    int          id;
  } exp_t;

  localparam int NV = 12;

  vec_t        tbl [NV];
  exp_t        sb [$];
  exp_t        mon_e;
  logic [3:0]  mon_got;
  logic [7:0]  frm [0:30];
  logic [39:0] model_fields;
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;
  bit          abort_pending = 1'b0;
  logic        abort_expect = 1'b0;

  always @(posedge clk_pixel) edge_cnt <= edge_cnt + 1;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void push(input logic [3:0] p, input int id);
    exp_t e;
    e.due    = edge_cnt;
    e.pulses = p;
    e.fields = model_fields;
    e.id     = id;
    sb.push_back(e);
  endfunction

  // Reference classification of the frame in frm: {abort, fmt, cks, valid}
  function automatic logic [3:0] classify();
    logic [7:0] s;
    if (frm[0] != 8'h82) return 4'b0000;
    if (frm[1] != 8'h02 || frm[2][7:5] != 3'd0 || frm[2][4:0] > 5'd27) return 4'b0100;
    s = 8'h00;
    for (int i = 0; i <= int'(frm[2][4:0]) + 3; i++) s += frm[i];
    return (s == 8'h00) ? 4'b0001 : 4'b0010;
  endfunction

  task automatic build_frame(input vec_t v);
    logic [7:0] s;
    int last;
    for (int i = 0; i < 31; i++) frm[i] = 8'h00;
    frm[0] = v.hb0; frm[1] = v.hb1; frm[2] = v.hb2;
    frm[4] = v.pb1; frm[5] = v.pb2; frm[7] = v.pb4; frm[8] = v.pb5;
    frm[13] = v.junk;
    last = int'(v.hb2[4:0]) + 3;
    if (last > 30) last = 30;
    s = 8'h00;
    for (int i = 0; i <= last; i++) if (i != 3) s += frm[i];
    frm[3] = (8'h00 - s) + v.ck_delta;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] b);
    pkt_valid = v;
    pkt_start = s;
    pkt_byte  = b;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic send_bytes(input int first, input int last_i, input bit stall, input bit with_start);
    for (int i = first; i <= last_i; i++) begin
      if (stall) drive(1'b0, 1'b1, 8'($urandom));
      drive(1'b1, with_start && (i == 0), frm[i]);
      if (i == 0 && with_start && abort_pending) begin
        push({abort_expect, 3'b000}, -2);
        abort_pending = 1'b0;
      end
    end
    pkt_valid = 1'b0;
    pkt_start = 1'b0;
  endtask

  task automatic send_frame(input int id, input bit stall);
    logic [3:0] p;
    send_bytes(0, 30, stall, 1'b1);
    p = classify();
    if (p == 4'b0001) model_fields = {frm[8], frm[7], frm[6], frm[5], frm[4]};
    push(p, id);
  endtask

  task automatic send_partial(input int n);
    send_bytes(0, n - 1, 1'b0, 1'b1);
    abort_pending = 1'b1;
    abort_expect  = (frm[0] == 8'h82);
  endtask

  always @(negedge clk_pixel) begin
    mon_got = {abort_err, format_err, checksum_err, avi_valid};
    if (sb.size() > 0 && sb[0].due < edge_cnt) begin
      mon_e = sb.pop_front();
      chk($sformatf("missed_result[%0d]", mon_e.id), 64'(0), 64'(1));
    end else if (sb.size() > 0 && sb[0].due == edge_cnt) begin
      mon_e = sb.pop_front();
      $display("txn %0d: pulses=%b fields=%h", mon_e.id, mon_got, avi_fields);
      chk($sformatf("pulses[%0d]", mon_e.id), 64'(mon_got), 64'(mon_e.pulses));
      chk($sformatf("avi_fields[%0d]", mon_e.id), 64'(avi_fields), 64'(mon_e.fields));
      chk($sformatf("video_id_code[%0d]", mon_e.id), 64'(video_id_code), 64'(mon_e.fields[30:24]));
      chk($sformatf("fmt_col_pr[%0d]", mon_e.id), 64'({video_format, colorimetry, pixel_repetition}),
          64'({mon_e.fields[6:5], mon_e.fields[15:14], mon_e.fields[35:32]}));
    end else if (mon_got != 4'b0000) begin
      chk("unexpected_pulse", 64'(mon_got), 64'(0));
    end
  end

  initial begin
    tbl[0]  = '{8'h82, 8'h02, 8'h0D, 8'h00, 8'h08, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'h82, 8'h02, 8'h0D, 8'h00, 8'h08, 8'h04, 8'h00, 8'h00, 8'h01, 1'b0};
    tbl[2]  = '{8'h84, 8'h01, 8'h0A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00, 1'b0};
    tbl[3]  = '{8'h82, 8'h02, 8'h0D, 8'h00, 8'h08, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{8'h82, 8'h03, 8'h0D, 8'h00, 8'h08, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{8'h82, 8'h02, 8'h1F, 8'h00, 8'h08, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{8'h82, 8'h02, 8'h0D, 8'h40, 8'hC8, 8'h10, 8'h03, 8'h5A, 8'h00, 1'b1};
    tbl[7]  = '{8'h82, 8'h02, 8'h05, 8'h20, 8'h48, 8'h5F, 8'h01, 8'hAA, 8'h00, 1'b0};
    tbl[8]  = '{8'h82, 8'h02, 8'h2D, 8'h00, 8'h08, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h82, 8'h02, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h80, 1'b1};
    tbl[10] = '{8'h82, 8'h02, 8'h00, 8'h1C, 8'h2D, 8'h3E, 8'h4F, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{8'h82, 8'h02, 8'h1B, 8'h60, 8'hA8, 8'h7F, 8'h0F, 8'hC3, 8'h00, 1'b0};

    reset_n = 1'b0; pkt_valid = 1'b0; pkt_start = 1'b0; pkt_byte = 8'h00;
    model_fields = 40'd0;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("reset_pulses", 64'({abort_err, format_err, checksum_err, avi_valid}), 64'(0));
    chk("reset_fields", 64'(avi_fields), 64'(0));
    chk("reset_decoded", 64'({video_format, colorimetry, video_id_code, pixel_repetition}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk_pixel);
    #1;

    // Bytes without pkt_start in IDLE are ignored
    drive(1'b1, 1'b0, 8'h82);
    drive(1'b1, 1'b0, 8'h02);
    pkt_valid = 1'b0;
    push(4'b0000, -1);

    for (int t = 0; t < NV; t++) begin
      build_frame(tbl[t]);
      send_frame(t, tbl[t].stall);
    end

    // Abort an AVI packet at PB10, then a full frame
    build_frame(tbl[0]);
    send_partial(13);
    build_frame(tbl[7]);
    send_frame(20, 1'b0);

    // Abort a non-AVI packet: no abort pulse
    build_frame(tbl[2]);
    send_partial(20);
    build_frame(tbl[0]);
    send_frame(21, 1'b0);

    // Reset asserted after PB5; rest of the packet arrives without a start
    build_frame(tbl[11]);
    send_bytes(0, 8, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_pulses", 64'({abort_err, format_err, checksum_err, avi_valid}), 64'(0));
    chk("midreset_fields", 64'(avi_fields), 64'(0));
    chk("midreset_vic", 64'(video_id_code), 64'(0));
    model_fields = 40'd0;
    @(posedge clk_pixel);
    #2 reset_n = 1'b1;
    send_bytes(9, 30, 1'b0, 1'b0);
    push(4'b0000, 22);
    build_frame(tbl[0]);
    send_frame(23, 1'b0);

    for (int w = 0; w < 50 && sb.size() > 0; w++) @(posedge clk_pixel);
    if (sb.size() > 0) chk("scoreboard_drain", 64'(sb.size()), 64'(0));
    repeat (3) @(posedge clk_pixel);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
